exe_div: RTL and testbench

- Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
- Accepts operands from the EXE datapath and holds stall_req until the result is ready.
- Delivers a 64-bit {remainder, quotient} that EXE forwards on the HI/LO double-word path into the EXE/MEM pipeline register.
- One division in flight at a time; a pipeline flush cancels it.

---
 rtl/exe_div_pkg.sv | 26 ++
 rtl/exe_div_if.sv | 28 ++
 rtl/exe_div.sv | 131 +++++++++++++
 tb/tb_exe_div.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_div_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exe_div_pkg : shared state encoding and bus constants for exe_div      |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
package exe_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam logic RST_ENABLE    = 1'b0;

    localparam int          DOUBLE_REG_BUS = 64;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic [63:0] ZERO_DWORD     = 64'h0;

endpackage
`default_nettype wire

// File: rtl/exe_div_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exe_div_if : EXE-stage <-> divider handshake and operand/result bus    |
// | Revision   : 1.0                                                       |
// +-----------------------------------------------------------------------+
interface exe_div_if #(
    parameter int DATA_W = 32
);
    logic                  div_start;
    logic                  div_signed;
    logic                  div_annul;
    logic [DATA_W-1:0]     dividend;
    logic [DATA_W-1:0]     divisor;
    logic [2*DATA_W-1:0]   div_result;
    logic                  div_ready;
    logic                  stall_req;

    modport master (
        output div_start, div_signed, div_annul, dividend, divisor,
        input  div_result, div_ready, stall_req
    );

    modport slave (
        input  div_start, div_signed, div_annul, dividend, divisor,
        output div_result, div_ready, stall_req
    );
endinterface
`default_nettype wire

// File: rtl/exe_div.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exe_div : multi-cycle radix-2 restoring divider (DIV/DIVU), EXE stage  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module exe_div
    import exe_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  wire        cpu_clk_50M,
    input  wire        cpu_rst_n,
    exe_div_if.slave   bus
);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  w_dvd_neg, w_dvs_neg;
    logic [DATA_W-1:0]     w_dvd_abs, w_dvs_abs;
    logic [DATA_W:0]       w_shift, w_diff;
    logic [DATA_W-1:0]     w_rem_step, w_quo_step;

    assign w_dvd_neg  = bus.div_signed & bus.dividend[DATA_W-1];
    assign w_dvs_neg  = bus.div_signed & bus.divisor[DATA_W-1];
    assign w_dvd_abs  = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_abs  = w_dvs_neg ? -bus.divisor  : bus.divisor;

    // One restoring step: the 33-bit trial difference's MSB is the borrow.
    assign w_shift    = {rem_q, quo_q[DATA_W-1]};
    assign w_diff     = w_shift - {1'b0, dvs_q};
    assign w_rem_step = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
    assign w_quo_step = {quo_q[DATA_W-2:0], ~w_diff[DATA_W]};

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = DIV_NOT_READY;

        if (bus.div_annul) begin
            state_d  = DIV_FREE;
            result_d = '0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    if (bus.div_start == DIV_START) begin
                        cnt_d  = '0;
                        rem_d  = '0;
                        qneg_d = w_dvd_neg ^ w_dvs_neg;
                        rneg_d = w_dvd_neg;
                        if (bus.divisor == '0) begin
                            // Raw dividend is parked in quo_q to become the HI word.
                            state_d = DIV_BYZERO;
                            quo_d   = bus.dividend;
                        end else begin
                            state_d = DIV_ON;
                            quo_d   = w_dvd_abs;
                            dvs_d   = w_dvs_abs;
                        end
                    end
                end
                DIV_BYZERO: begin
                    state_d  = DIV_END;
                    ready_d  = DIV_READY;
                    result_d = {quo_q, {DATA_W{1'b1}}};
                end
                DIV_ON: begin
                    rem_d = w_rem_step;
                    quo_d = w_quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = DIV_END;
                        ready_d  = DIV_READY;
                        result_d = {rneg_q ? -w_rem_step : w_rem_step,
                                    qneg_q ? -w_quo_step : w_quo_step};
                    end
                end
                DIV_END: begin
                    state_d = DIV_FREE;
                end
                default: begin
                    state_d = DIV_FREE;
                end
            endcase
        end
    end

    assign bus.div_result = result_q;
    assign bus.div_ready  = ready_q;
    assign bus.stall_req  = bus.div_start & ~ready_q & ~bus.div_annul;

endmodule
`default_nettype wire

// File: tb/tb_exe_div.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_exe_div : self-checking bench for exe_div against an arithmetic ref |
// | Revision   : 1.0                                                       |
// +-----------------------------------------------------------------------+
module tb_exe_div;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exe_div_if #(.DATA_W(32)) bus();

    exe_div #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .bus         (bus)
    );

    always #10 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one divide with start held until ready; reports what was observed.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int rdy_cyc, output logic [63:0] res,
                           output int stall_cnt, output logic stall_at_rdy,
                           output logic rdy_after);
        @(posedge clk); #1;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = sgn;
        bus.div_start  = 1'b1;
        rdy_cyc = 0; res = '0; stall_cnt = 0; stall_at_rdy = 1'bx; rdy_after = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.div_ready === 1'b1) begin
                rdy_cyc      = c;
                res          = bus.div_result;
                stall_at_rdy = bus.stall_req;
                break;
            end
            if (bus.stall_req === 1'b1) stall_cnt++;
            if (c > 1) begin
                bus.dividend   = $urandom;
                bus.divisor    = $urandom;
                bus.div_signed = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        @(negedge clk);
        rdy_after = bus.div_ready;
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.div_result !== 64'h0 || bus.div_ready !== 1'b0 || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: result=%h ready=%b stall=%b required 0/0/0",
                     bus.div_result, bus.div_ready, bus.stall_req);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.div_result !== 64'h0 || bus.div_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: result=%h ready=%b required 0/0",
                     bus.div_result, bus.div_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_1234};
        logic [31:0] tb [5] = '{32'd7,   32'd2,         32'd2,         32'hFFFF_FFFF, 32'h0};
        logic        ts [5] = '{1'b0,    1'b1,          1'b0,          1'b1,          1'b0};
        logic [63:0] te [5] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                                64'h00000001_7FFFFFFC, 64'h00000000_80000000,
                                64'h00001234_FFFFFFFF};
        int          tl [5] = '{34, 34, 34, 34, 3};
        int rc, sc; logic [63:0] res; logic sr, ra;
        for (int i = 0; i < 5; i++) begin
            run_div(ta[i], tb[i], ts[i], rc, res, sc, sr, ra);
            checks++;
            if (res !== te[i]) begin
                errors++;
                $display("FAIL directed%0d_result: got %h required %h", i, res, te[i]);
            end
            checks++;
            if (rc != tl[i]) begin
                errors++;
                $display("FAIL directed%0d_latency: ready in cycle %0d required %0d", i, rc, tl[i]);
            end
            checks++;
            if (sc != tl[i] - 1 || sr !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_stall: high %0d cycles, at ready %b; required %0d, 0",
                         i, sc, sr, tl[i] - 1);
            end
            checks++;
            if (ra !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_ready_pulse: ready after END %b required 0", i, ra);
            end
        end
    endtask

    task automatic test_annul();
        bit seen = 1'b0;
        int rc, sc; logic [63:0] res; logic sr, ra;
        @(posedge clk); #1;
        bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.div_signed = 1'b0;
        bus.div_start = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        bus.div_annul = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL annul_stall: got %b required 0", bus.stall_req);
        end
        @(posedge clk); #1;
        bus.div_annul = 1'b0;
        bus.div_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.div_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || bus.div_result !== 64'h0) begin
            errors++;
            $display("FAIL annul_cancel: ready_seen=%b result=%h required 0/0", seen, bus.div_result);
        end
        run_div(32'd9, 32'd3, 1'b0, rc, res, sc, sr, ra);
        checks++;
        if (rc != 34 || res !== 64'h00000000_00000003) begin
            errors++;
            $display("FAIL after_annul: cycle %0d result %h required 34 / 0000000000000003", rc, res);
        end
    endtask

    task automatic test_async_reset_b2b();
        bit seen = 1'b0;
        int cyc [$];
        logic [63:0] got [$];
        logic [63:0] e1, e2;
        @(posedge clk); #1;
        bus.dividend = 32'd50; bus.divisor = 32'd5; bus.div_signed = 1'b0;
        bus.div_start = 1'b1;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.div_start = 1'b0;
        #1;
        checks++;
        if (bus.div_result !== 64'h0 || bus.div_ready !== 1'b0 || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: result=%h ready=%b stall=%b required 0/0/0",
                     bus.div_result, bus.div_ready, bus.stall_req);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.div_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_abandon: ready rose after reset, required never");
        end
        e1 = model(32'd1000, 32'd7, 1'b0);
        e2 = model(32'hFFFF_FF9C, 32'd9, 1'b1);
        @(posedge clk); #1;
        bus.dividend = 32'd1000; bus.divisor = 32'd7; bus.div_signed = 1'b0;
        bus.div_start = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (bus.div_ready === 1'b1) begin
                cyc.push_back(c);
                got.push_back(bus.div_result);
            end
            if (c == 2) begin
                bus.dividend = 32'hFFFF_FF9C; bus.divisor = 32'd9; bus.div_signed = 1'b1;
            end
            if (cyc.size() == 2) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        checks++;
        if (cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d completions required 2", cyc.size());
        end else begin
            if (cyc[0] != 34 || cyc[1] != 68) begin
                errors++;
                $display("FAIL b2b_timing: cycles %0d,%0d required 34,68", cyc[0], cyc[1]);
            end
            checks++;
            if (got[0] !== e1 || got[1] !== e2) begin
                errors++;
                $display("FAIL b2b_result: got %h,%h required %h,%h", got[0], got[1], e1, e2);
            end
        end
    endtask

    task automatic test_random();
        int rc, sc; logic [63:0] res, exp_r; logic sr, ra;
        logic [31:0] a, b; logic s; int lat;
        for (int i = 0; i < 30; i++) begin
            a = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            s     = 1'($urandom_range(0, 1));
            exp_r = model(a, b, s);
            lat   = (b == 32'h0) ? 3 : 34;
            run_div(a, b, s, rc, res, sc, sr, ra);
            checks++;
            if (res !== exp_r || rc != lat || ra !== 1'b0) begin
                errors++;
                $display("FAIL random%0d: %h/%h s=%b got %h cyc %0d post %b required %h cyc %0d post 0",
                         i, a, b, s, res, rc, ra, exp_r, lat);
            end
        end
    endtask

    initial begin
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_annul  = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        test_reset();
        test_directed();
        test_annul();
        test_async_reset_b2b();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
